// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing defaults and the packed sync-bit bundle.
package vga_timing_pkg;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_COORD_W  = 10;
    localparam int DEF_FRAME_W  = 8;

    typedef struct packed {
        logic display;
        logic h_sync;
        logic v_sync;
    } sync_bits_t;
endpackage

// File: rtl/vga_timing_pipe_if.sv
// vga_timing_pipe_if: pixel enable in, raster coordinates and sync/strobe outputs out.
interface vga_timing_pipe_if
    import vga_timing_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int FRAME_W = DEF_FRAME_W
) ();
    logic               pix_ce;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               display;
    logic               h_sync;
    logic               v_sync;
    logic               line_start;
    logic               frame_start;
    logic [FRAME_W-1:0] frame_cnt;
    logic               display_d;
    logic               h_sync_d;
    logic               v_sync_d;

    modport master (
        input  pix_ce,
        output x, y, display, h_sync, v_sync, line_start, frame_start,
               frame_cnt, display_d, h_sync_d, v_sync_d
    );

    modport slave (
        output pix_ce,
        input  x, y, display, h_sync, v_sync, line_start, frame_start,
               frame_cnt, display_d, h_sync_d, v_sync_d
    );
endinterface

// File: rtl/sync_delay_line.sv
// sync_delay_line: DEPTH-stage, 3-bit, clock-enabled shift register with per-bit reset values.
module sync_delay_line #(
    parameter int         DEPTH   = 0,
    parameter logic [2:0] RST_VAL = 3'b000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic [2:0] din,
    output logic [2:0] dout
);
    if (DEPTH == 0) begin : g_bypass
        logic unused_ok;
        assign unused_ok = &{1'b0, clk, rst_n, ce};
        assign dout = din;
    end else begin : g_shift
        logic [2:0] sr [DEPTH];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
            end else if (ce) begin
                sr[0] <= din;
                for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
            end
        end
        assign dout = sr[DEPTH-1];
    end
endmodule

// File: rtl/vga_timing_pipe.sv
// vga_timing_pipe: VGA raster counters with registered display/sync, frame counter and a renderer-latency delay line.
module vga_timing_pipe
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit H_POL      = 1'b0,
    parameter bit V_POL      = 1'b0,
    parameter int COORD_W    = DEF_COORD_W,
    parameter int PIPE_DELAY = 0,
    parameter int FRAME_W    = DEF_FRAME_W
) (
    input logic              clk,
    input logic              rst_n,
    vga_timing_pipe_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT  = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT  = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_BEG = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_BEG = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam sync_bits_t RST_SYNC = '{display: 1'b0, h_sync: ~H_POL, v_sync: ~V_POL};

    logic [COORD_W-1:0] x, y, x_nxt, y_nxt;
    logic [FRAME_W-1:0] frame_cnt;
    logic               wrap_x, wrap_frame;
    sync_bits_t         cur, nxt, dly;

    // Sync/display are decoded from the next position so the registered copy lines up with x/y.
    always_comb begin
        wrap_x      = x == H_LAST;
        wrap_frame  = wrap_x && y == V_LAST;
        x_nxt       = wrap_x ? '0 : x + 1'b1;
        y_nxt       = wrap_frame ? '0 : wrap_x ? y + 1'b1 : y;
        nxt.display = x_nxt < H_ACT && y_nxt < V_ACT;
        nxt.h_sync  = (x_nxt >= HS_BEG && x_nxt < HS_END) ? H_POL : ~H_POL;
        nxt.v_sync  = (y_nxt >= VS_BEG && y_nxt < VS_END) ? V_POL : ~V_POL;
    end

    // Reset parks at the last pixel of the last line so the first enable lands on (0,0), frame 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x         <= H_LAST;
            y         <= V_LAST;
            frame_cnt <= '1;
            cur       <= RST_SYNC;
        end else if (bus.pix_ce) begin
            x   <= x_nxt;
            y   <= y_nxt;
            cur <= nxt;
            if (wrap_frame) frame_cnt <= frame_cnt + 1'b1;
        end
    end

    sync_delay_line #(
        .DEPTH   (PIPE_DELAY),
        .RST_VAL (RST_SYNC)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (bus.pix_ce),
        .din   (cur),
        .dout  (dly)
    );

    assign bus.x           = x;
    assign bus.y           = y;
    assign bus.frame_cnt   = frame_cnt;
    assign bus.display     = cur.display;
    assign bus.h_sync      = cur.h_sync;
    assign bus.v_sync      = cur.v_sync;
    assign bus.line_start  = bus.pix_ce && x == '0;
    assign bus.frame_start = bus.pix_ce && x == '0 && y == '0;
    assign bus.display_d   = dly.display;
    assign bus.h_sync_d    = dly.h_sync;
    assign bus.v_sync_d    = dly.v_sync;
endmodule

// File: doc/vga_timing_pipe.md
VGA_TIMING_PIPE -- requirements
Module: vga_timing_pipe

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal porch and sync widths in pixels; each SHALL be at least 1.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical porch and sync widths in lines; each SHALL be at least 1.
REQ-005 SHALL have parameters H_POL / V_POL, default 0 / 0, active level of h_sync / v_sync (0 = active-low).
REQ-006 SHALL have parameter COORD_W, default 10, counter and coordinate width; it SHALL hold H_TOTAL-1 and V_TOTAL-1.
REQ-007 SHALL have parameter PIPE_DELAY, default 0 (range 0..15), renderer latency in pixels to compensate.
REQ-008 SHALL have parameter FRAME_W, default 8, frame counter width.
REQ-009 Ports: clk  in  1  clock.
REQ-010 Ports: rst_n  in  1  reset; one clock domain, reset asynchronous, active-low.
REQ-011 Ports: pix_ce  in  1  pixel clock enable; all state advances only on clk edges with pix_ce=1.
REQ-012 Ports: x, y  out  COORD_W  current horizontal / vertical counter.
REQ-013 Ports: display  out  1  high when x<H_ACTIVE and y<V_ACTIVE.
REQ-014 Ports: h_sync, v_sync  out  1  undelayed sync at H_POL / V_POL level.
REQ-015 Ports: line_start, frame_start  out  1  pix_ce-qualified pulses.
REQ-016 Ports: frame_cnt  out  FRAME_W  frame number.
REQ-017 Ports: display_d, h_sync_d, v_sync_d  out  1  same signals delayed PIPE_DELAY pixels.

Function
REQ-018 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP, computed at elaboration.
REQ-019 On pix_ce, x SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and y SHALL increment; at y=V_TOTAL-1 with the x wrap, y SHALL wrap to 0.
REQ-020 When pix_ce=0, all registers SHALL hold.
REQ-021 h_sync SHALL be at H_POL exactly when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, else at ~H_POL; v_sync is analogous on y with V_* parameters.
REQ-022 display, h_sync and v_sync SHALL be registered outputs, aligned to the current x/y with zero-cycle skew.
REQ-023 line_start SHALL equal (x==0 and pix_ce); frame_start SHALL equal (x==0, y==0, pix_ce).
REQ-024 frame_cnt SHALL increment modulo 2^FRAME_W on the pix_ce edge that moves (x,y) to (0,0).
REQ-025 The *_d outputs SHALL be a PIPE_DELAY-stage shift register advanced only on pix_ce; PIPE_DELAY=0 SHALL make them equal the undelayed outputs.

Reset
REQ-026 During reset, x=H_TOTAL-1 and y=V_TOTAL-1, so the first pix_ce after release yields (0,0).
REQ-027 During reset, frame_cnt SHALL be all-ones, so the first frame after release reads 0.
REQ-028 During reset, display, display_d and all delay stages SHALL be 0; h_sync, h_sync_d, v_sync and v_sync_d SHALL be at the inactive level.
REQ-029 Reset asserted mid-frame SHALL return all state to REQ-026..028 values immediately, without waiting for a clock.

Structure
REQ-030 Package vga_timing_pkg SHALL hold the 640x480@60 defaults, H_TOTAL=800 and V_TOTAL=525.
REQ-031 The delay SHALL be one sub-module, sync_delay_line: a 3-bit-wide shift register of PIPE_DELAY stages with clock enable and per-bit reset values.

Verification
REQ-032 Release reset with pix_ce=1: the first cycle SHALL show x=0, y=0, display=1, line_start=1, frame_start=1, frame_cnt=0.
REQ-033 Defaults, pix_ce=1: h_sync SHALL be low for x=656..751 only (96 cycles per 800-cycle line); display SHALL be high 640 cycles per line.
REQ-034 Defaults: v_sync SHALL be low for y=490..491 only, i.e. 1600 consecutive cycles per 420000-cycle frame.
REQ-035 pix_ce toggling 1/0: counters SHALL hold on off cycles, line period SHALL be 1600 clocks, and line_start SHALL pulse only on a ce cycle.
REQ-036 PIPE_DELAY=3: display_d SHALL rise 3 pix_ce edges after display; with PIPE_DELAY=0, the *_d outputs SHALL equal the undelayed outputs every cycle.
REQ-037 FRAME_W=2, small timing (H 4/1/1/1, V 3/1/1/1): frame_cnt SHALL run 0,1,2,3,0; asserting rst_n=0 mid-line SHALL restore REQ-026..028 values without a clock edge.
